// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   byteen;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational two-way picker: a lone requester wins, a tie goes to the master not granted last.
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       win_id,
  output logic       win_valid
);

  always_comb begin
    win_valid = |req;
    win_id    = M0;
    case (req)
      2'b10:   win_id = M1;
      2'b11:   win_id = (last_gnt == M1) ? M0 : M1;
      default: win_id = M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of a single slave bridge port; IDLE -> ACCESS -> RESP per transaction.
// Define BUS_ARB_FIXED_PRI_EN to make master 0 always win ties (no last-granted state).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_byteen,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_byteen,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [BE_W-1:0]   s_byteen,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  bus_req_t          lat;
  logic              lat_id;
  logic              last_gnt;
  logic              pick_id;
  logic              pick_valid;
  logic              take;
  logic              final_access;
  bus_req_t          m0_bus;
  bus_req_t          m1_bus;
  bus_req_t          win_bus;

  assign m0_bus  = '{addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};
  assign m1_bus  = '{addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen};
  assign win_bus = (pick_id == M1) ? m1_bus : m0_bus;

  bus_arb_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .win_id    (pick_id),
    .win_valid (pick_valid)
  );

  // Grant is decided and pulsed in the IDLE cycle that sees the request.
  assign take         = !reset && (state == IDLE) && pick_valid;
  assign m0_gnt       = take && (pick_id == M0);
  assign m1_gnt       = take && (pick_id == M1);
  assign final_access = (state == ACCESS) && (wait_cnt == LAST_WAIT);
  assign wait_nxt     = wait_cnt + WAIT_W'(1);
  assign s_addr       = lat.addr;
  assign s_wdata      = lat.wdata;

`ifdef BUS_ARB_FIXED_PRI_EN
  assign last_gnt = M1;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_gnt <= M1;
    else if (take) last_gnt <= pick_id;
  end
`endif

  // Transaction FSM; byteen is staged so it reaches the bridge only in the last ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat       <= '0;
      lat_id    <= M0;
      s_byteen  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            lat      <= win_bus;
            lat_id   <= pick_id;
            wait_cnt <= '0;
            s_byteen <= (LAST_WAIT == '0) ? win_bus.byteen : '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (final_access) begin
            s_byteen <= '0;
            state    <= RESP;
            if (lat_id == M0) begin
              m0_rvalid <= 1'b1;
              m0_rdata  <= s_rdata;
            end else begin
              m1_rvalid <= 1'b1;
              m1_rdata  <= s_rdata;
            end
          end else begin
            wait_cnt <= wait_nxt;
            s_byteen <= (wait_nxt == LAST_WAIT) ? lat.byteen : '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a transaction-level model predicts grants and responses.
module tb_bus_arbiter;

  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_byteen, m1_byteen, s_byteen;
  logic [31:0] s_addr, s_wdata, s_rdata;

  logic        req_v[2];
  logic [31:0] addr_v[2];
  logic [31:0] wdata_v[2];
  logic [3:0]  be_v[2];

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          g;
  } txn_t;

  txn_t gnt_q[$];
  txn_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   free_at = 0;
  int   last = 1;
  int   cyc = 0;

  assign m0_req = req_v[0];  assign m0_addr = addr_v[0];
  assign m0_wdata = wdata_v[0]; assign m0_byteen = be_v[0];
  assign m1_req = req_v[1];  assign m1_addr = addr_v[1];
  assign m1_wdata = wdata_v[1]; assign m1_byteen = be_v[1];

  // Bridge model: read data tags the address with the cycle it was sampled in.
  assign s_rdata = {s_addr[15:0], cyc[15:0]};

  bus_arbiter #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic new_op(input int m);
    req_v[m]   = 1'b1;
    addr_v[m]  = $urandom;
    wdata_v[m] = $urandom;
    be_v[m]    = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
  endtask

  // Arbitration from the rules: free slot every 3+WC cycles, ties to the other master.
  task automatic model_decide(output int win);
    txn_t t;
    win = -1;
    if (!reset && cyc >= free_at && (req_v[0] || req_v[1])) begin
      if (req_v[0] && req_v[1]) begin
`ifdef BUS_ARB_FIXED_PRI_EN
        win = 0;
`else
        win = (last == 1) ? 0 : 1;
`endif
      end else begin
        win = req_v[0] ? 0 : 1;
      end
      t.id = win; t.addr = addr_v[win]; t.wdata = wdata_v[win];
      t.be = be_v[win]; t.g = cyc;
      gnt_q.push_back(t);
      rsp_q.push_back(t);
      last    = win;
      free_at = cyc + 3 + int'(WC);
    end
  endtask

  task automatic cycle_step(input int p_new, input int p_drop);
    int win;
    @(negedge clk);
    model_decide(win);
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      if (m == win) begin
        if (int'($urandom_range(99)) < p_drop) req_v[m] = 1'b0;
        else new_op(m);
      end else if (!req_v[m]) begin
        if (int'($urandom_range(99)) < p_new) new_op(m);
        else addr_v[m] = $urandom;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || req_v[0] || req_v[1]) && n < 200) begin
      cycle_step(0, 100);
      n++;
    end
    chk("drain_done", 32'(n < 200), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_s_addr"}, s_addr, 32'd0);
    chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    chk({tag, "_s_byteen"}, 32'(s_byteen), 32'd0);
  endtask

  // Monitor: compares every cycle against the head of the expectation queues.
  initial begin
    txn_t        t;
    int          c;
    logic [31:0] e_g0, e_g1, e_v0, e_v1, e_d0, e_d1, e_be;
    forever begin
      @(negedge clk); #1;
      c = cyc;
      e_g0 = '0; e_g1 = '0; e_v0 = '0; e_v1 = '0; e_d0 = '0; e_d1 = '0; e_be = '0;
      if (gnt_q.size() > 0 && gnt_q[0].g == c) begin
        t = gnt_q.pop_front();
        if (t.id == 0) e_g0 = 32'd1;
        else e_g1 = 32'd1;
      end
      chk("m0_gnt", 32'(m0_gnt), e_g0);
      chk("m1_gnt", 32'(m1_gnt), e_g1);
      if (rsp_q.size() > 0) begin
        t = rsp_q[0];
        if (c >= t.g + 1 && c <= t.g + 1 + int'(WC)) begin
          chk("s_addr", s_addr, t.addr);
          chk("s_wdata", s_wdata, t.wdata);
          if (c == t.g + 1 + int'(WC)) e_be = 32'(t.be);
        end
        if (c == t.g + 2 + int'(WC)) begin
          void'(rsp_q.pop_front());
          if (t.id == 0) begin
            e_v0 = 32'd1; e_d0 = {t.addr[15:0], 16'(t.g + 1 + int'(WC))};
          end else begin
            e_v1 = 32'd1; e_d1 = {t.addr[15:0], 16'(t.g + 1 + int'(WC))};
          end
        end
      end
      chk("s_byteen", 32'(s_byteen), e_be);
      chk("m0_rvalid", 32'(m0_rvalid), e_v0);
      chk("m1_rvalid", 32'(m1_rvalid), e_v1);
      chk("m0_rdata", m0_rdata, e_d0);
      chk("m1_rdata", m1_rdata, e_d1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    new_op(0);
    new_op(1);
    @(negedge clk); #2;
    chk_reset_vals("rst");
    @(posedge clk); #3;
    reset = 1'b0;

    // Both masters request continuously.
    repeat (24) cycle_step(100, 0);
    // Random traffic with drops and operand changes after grant.
    repeat (300) cycle_step(40, 50);
    drain();

    // Reset during the first ACCESS cycle of an m0 write after m0 was granted last.
    new_op(0);
    be_v[0] = 4'hF;
    @(negedge clk);
    model_decide(win);
    chk("pre_reset_winner", 32'(win), 32'd0);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    reset = 1'b1;
    gnt_q.delete();
    rsp_q.delete();
    free_at = 0;
    last = 1;
    #1;
    chk("rst_access_s_byteen", 32'(s_byteen), 32'd0);
    @(negedge clk); #2;
    chk_reset_vals("rst_mid");
    @(posedge clk); #3;
    new_op(0);
    new_op(1);
    reset = 1'b0;
    repeat (12) cycle_step(100, 0);
    repeat (150) cycle_step(50, 50);
    drain();

    chk("queues_empty", 32'(gnt_q.size() + rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, range 0-7: extra slave-access cycles per transaction.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Ports m0_req / m1_req  input  1  master 0 (CPU data port) / master 1 (DMA/debug) transaction request.
REQ-005 Ports m0_addr / m1_addr  input  32  byte address; m0_wdata / m1_wdata  input  32  write data.
REQ-006 Ports m0_byteen / m1_byteen  input  4  byte enables; 4'b0000 means read.
REQ-007 Ports m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted, its operands latched.
REQ-008 Ports m0_rvalid / m1_rvalid  output  1  one-cycle pulse: transaction complete, rdata valid.
REQ-009 Ports m0_rdata / m1_rdata  output  32  read data, valid only while the matching rvalid is high.
REQ-010 Ports s_addr / s_wdata  output  32  and s_byteen  output  4  drive the bridge CPU-side port.
REQ-011 Port s_rdata  input  32  combinational read data returned by the bridge.

Function
REQ-012 FSM states: IDLE, ACCESS, RESP.
REQ-013 IDLE, no request: remain IDLE; gnt low.
REQ-014 IDLE, one or more requests: select a winner, pulse its gnt in the same cycle, latch its addr/wdata/byteen and ID, go to ACCESS.
REQ-015 Round-robin: if both masters request, grant the master not granted last; a single requester is always granted.
REQ-016 ACCESS lasts 1+WAIT_CYCLES cycles, counted by a 3-bit wait counter; s_addr and s_wdata drive the latched values for the whole state.
REQ-017 s_byteen equals the latched byteen only in the final ACCESS cycle; otherwise 4'b0000. A write therefore commits exactly once.
REQ-018 At the end of the final ACCESS cycle, register s_rdata into a read-data register and go to RESP.
REQ-019 RESP lasts one cycle: assert rvalid of the latched ID; that master's rdata shows the register; go to IDLE.
REQ-020 Latency with WAIT_CYCLES=0: gnt in cycle N, s_byteen valid in N+1, rvalid in N+2. Throughput: one transaction per 3+WAIT_CYCLES cycles.
REQ-021 Requests are ignored in ACCESS and RESP; an un-granted master holds req and operands until its gnt.
REQ-022 A master may drop req or change operands in the cycle after its gnt with no effect on the in-flight transaction.
REQ-023 Non-selected master's rdata is 32'h0000_0000; the other master's rvalid stays low.

Reset
REQ-024 Reset asserted forces IDLE immediately; the in-flight transaction is discarded with no rvalid.
REQ-025 Reset values: all gnt, rvalid 0; all rdata, s_addr, s_wdata 32'h0; s_byteen 4'b0000; wait counter 0; last-granted = master 1, so master 0 wins first.
REQ-026 Reset during ACCESS drops s_byteen to 4'b0000 asynchronously; no write commits.

Configuration
REQ-027 Macro BUS_ARB_FIXED_PRI_EN, when defined: master 0 always wins simultaneous requests; the last-granted register is absent.
REQ-028 Macro BUS_ARB_FIXED_PRI_EN undefined: round-robin per REQ-015.

Structure
REQ-029 Package bus_arb_pkg holds the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and master ID constants (M0=1'b0, M1=1'b1).
REQ-030 One sub-module, bus_arb_pick: a combinational two-way picker taking req[1:0] and last-granted and returning the winner ID and a valid bit.

Verification
REQ-031 m0 write addr 32'h0000_0010, wdata 32'hDEAD_BEEF, byteen 4'hF, WAIT_CYCLES=0 -> m0_gnt in cycle N; s_byteen=4'hF only in N+1; m0_rvalid in N+2.
REQ-032 m1 read of 32'h0000_7F04 with s_rdata=32'h0000_1234 during ACCESS -> m1_rvalid in N+2, m1_rdata=32'h0000_1234, m0_rvalid stays 0.
REQ-033 Both masters request continuously for 4 transactions -> grant order M0, M1, M0, M1; with BUS_ARB_FIXED_PRI_EN -> M0, M0, M0, M0.
REQ-034 WAIT_CYCLES=3 write -> ACCESS spans 4 cycles; s_byteen nonzero only in the 4th; rvalid 5 cycles after gnt.
REQ-035 Reset pulsed in the first ACCESS cycle of a write with WAIT_CYCLES=2 -> s_byteen never nonzero, no rvalid, IDLE after release, next dual request granted to M0.
REQ-036 m0_req asserted during RESP of an m1 transaction -> no gnt in RESP; m0_gnt in the following IDLE cycle.
